imm_rot_encoder: RTL and testbench

// - Inverse of the immediate rotator. Takes a 32-bit constant and searches for an 8-bit

---
 rtl/imm_rot_encoder.sv | 161 ++++++++++++++++
 tb/tb_imm_rot_encoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/imm_rot_encoder.sv
// Searches for an imm8/rot pair with value == ror32(imm8, ROT_STEP*rot); lowest rot wins.
// Define IMM_ROT_PARALLEL_EN to evaluate all candidates in one cycle instead of iterating.
module imm_rot_encoder #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IMM_W    = 8,
    parameter int unsigned ROT_W    = 4,
    parameter int unsigned ROT_STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_encodable,
    output logic [IMM_W-1:0]  out_imm8,
    output logic [ROT_W-1:0]  out_rot
);

    localparam int unsigned NUM_CAND = 1 << ROT_W;
    localparam int unsigned SHIFT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  value_q, value_d;
    logic [IMM_W-1:0]   imm8_q, imm8_d;
    logic [ROT_W-1:0]   rot_q, rot_d;
    logic               enc_q, enc_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    // Rotate left modulo DATA_W via a doubled word, avoiding a full-width shift by DATA_W.
    function automatic logic [DATA_W-1:0] rol(input logic [DATA_W-1:0] v,
                                              input logic [SHIFT_W-1:0] s);
        logic [2*DATA_W-1:0] t;
        t = {v, v} << s;
        return t[2*DATA_W-1 -: DATA_W];
    endfunction

`ifdef IMM_ROT_PARALLEL_EN
    logic              par_hit_c;
    logic [ROT_W-1:0]  par_rot_c;
    logic [IMM_W-1:0]  par_imm_c;
    logic [DATA_W-1:0] par_cand_c;

    // Descending scan so the lowest hitting k is the one left standing.
    always_comb begin
        par_hit_c  = 1'b0;
        par_rot_c  = '0;
        par_imm_c  = '0;
        par_cand_c = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            par_cand_c = rol(value_q, SHIFT_W'(ROT_STEP * i));
            if (par_cand_c[DATA_W-1:IMM_W] == '0) begin
                par_hit_c = 1'b1;
                par_rot_c = ROT_W'(i);
                par_imm_c = par_cand_c[IMM_W-1:0];
            end
        end
    end
`else
    logic [ROT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cand_c;

    assign cand_c = rol(value_q, SHIFT_W'(ROT_STEP * cnt_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state and result capture.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        imm8_d  = imm8_q;
        rot_d   = rot_q;
        enc_d   = enc_q;
`ifndef IMM_ROT_PARALLEL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    value_d = in_value;
`ifndef IMM_ROT_PARALLEL_EN
                    cnt_d   = '0;
`endif
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
`ifdef IMM_ROT_PARALLEL_EN
                imm8_d  = par_imm_c;
                rot_d   = par_rot_c;
                enc_d   = par_hit_c;
                state_d = S_DONE;
`else
                if (cand_c[DATA_W-1:IMM_W] == '0) begin
                    imm8_d  = cand_c[IMM_W-1:0];
                    rot_d   = cnt_q;
                    enc_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == ROT_W'(NUM_CAND - 1)) begin
                    imm8_d  = '0;
                    rot_d   = '0;
                    enc_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            value_q     <= '0;
            imm8_q      <= '0;
            rot_q       <= '0;
            enc_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            imm8_q      <= imm8_d;
            rot_q       <= rot_d;
            enc_q       <= enc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_encodable = enc_q;
    assign out_imm8      = imm8_q;
    assign out_rot       = rot_q;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Directed bench for imm_rot_encoder: encodings, latency, backpressure and mid-search reset.
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic        out_encodable;
    logic [7:0]  out_imm8;
    logic [3:0]  out_rot;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    imm_rot_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_value     (in_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_encodable(out_encodable),
        .out_imm8     (out_imm8),
        .out_rot      (out_rot)
    );

    // Edges from accept until out_valid is seen.
    function automatic int lat_for(input int k);
`ifdef IMM_ROT_PARALLEL_EN
        return 1;
`else
        return 1 + k;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present v, wait for the result, check it; leaves the DUT in DONE.
    task automatic start_and_wait(input string tag, input logic [31:0] v, input logic e,
                                  input logic [7:0] imm, input logic [3:0] rot, input int lat);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_value = v;
        step();
        in_valid = 1'b0;
        in_value = $urandom;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_enc"}, 32'(out_encodable), 32'(e));
        check({tag, "_imm8"}, 32'(out_imm8), 32'(imm));
        check({tag, "_rot"}, 32'(out_rot), 32'(rot));
    endtask

    task automatic run_vec(input string tag, input logic [31:0] v, input logic e,
                           input logic [7:0] imm, input logic [3:0] rot, input int lat);
        out_ready = 1'b1;
        start_and_wait(tag, v, e, imm, rot, lat);
        step();
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_enc", 32'(out_encodable), 32'd0);
        check("rst_imm8", 32'(out_imm8), 32'd0);
        check("rst_rot", 32'(out_rot), 32'd0);
        rst = 1'b0;
        step();

        run_vec("f1",       32'h000000F1, 1'b1, 8'hF1, 4'd0,  lat_for(0));
        run_vec("f000000f", 32'hF000000F, 1'b1, 8'hFF, 4'd2,  lat_for(2));
        run_vec("3fc00000", 32'h3FC00000, 1'b1, 8'hFF, 4'd5,  lat_for(5));
        run_vec("zero",     32'h00000000, 1'b1, 8'h00, 4'd0,  lat_for(0));
        run_vec("ff000000", 32'hFF000000, 1'b1, 8'hFF, 4'd4,  lat_for(4));
        run_vec("k15_hit",  32'h00000204, 1'b1, 8'h81, 4'd15, lat_for(15));
        run_vec("miss101",  32'h00000101, 1'b0, 8'h00, 4'd0,  lat_for(15));

        // Backpressure: result held, no accept while DONE.
        out_ready = 1'b0;
        start_and_wait("bp", 32'hF000000F, 1'b1, 8'hFF, 4'd2, lat_for(2));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_value = 32'h00000055;
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_imm8", 32'(out_imm8), 32'hFF);
            check("bp_rot", 32'(out_rot), 32'd2);
            check("bp_enc", 32'(out_encodable), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Reset mid-search (iterative) or with a result pending (parallel).
        check("rs_in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_value = 32'h00000101;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd1);
        check("rs_enc", 32'(out_encodable), 32'd0);
        check("rs_imm8", 32'(out_imm8), 32'd0);
        check("rs_rot", 32'(out_rot), 32'd0);
        step();
        check("rs_still_idle", 32'(out_valid), 32'd0);
        run_vec("post_rst_f1", 32'h000000F1, 1'b1, 8'hF1, 4'd0, lat_for(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
